// File: rtl/ssram_rmw_bridge.sv
// Valid/ready request front end for a single-port synchronous SRAM with a
// one-cycle registered read; partial-byte stores become read-modify-write.
module ssram_rmw_bridge #(
    parameter int WADDR = 10,
    parameter int WDATA = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [WADDR-1:0]   req_addr,
    input  logic [WDATA-1:0]   req_wdata,
    input  logic [WDATA/8-1:0] req_be,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WDATA-1:0]   rsp_rdata,
    output logic               mem_wr,
    output logic [WADDR-1:0]   mem_addr,
    output logic [WDATA-1:0]   mem_datain,
    input  logic [WDATA-1:0]   mem_dataout
);

    localparam int NBE = WDATA / 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_RSP  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic             wr_q;
    logic [WADDR-1:0] addr_q;
    logic [WDATA-1:0] wdata_q;
    logic [NBE-1:0]   be_q;
    logic [WDATA-1:0] datain_q, datain_d;
    logic [WDATA-1:0] rdata_q, rdata_d;
    logic [WDATA-1:0] merged;
    logic             accept;

    // Ready is gated by rst_n so it reads 0 while reset is held, yet rises
    // in the very first cycle after release.
    assign req_ready  = (state_q == S_IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign rsp_valid  = (state_q == S_RSP);
    assign rsp_rdata  = rdata_q;
    assign mem_wr     = (state_q == S_WR);
    assign mem_addr   = addr_q;
    assign mem_datain = datain_q;

    always_comb begin
        for (int i = 0; i < NBE; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_dataout[8*i +: 8];
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d  = state_q;
        datain_d = datain_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!req_wr) begin
                        state_d = S_RD;
                    end else if (&req_be) begin
                        state_d  = S_WR;
                        datain_d = req_wdata;
                    end else if (req_be == '0) begin
                        state_d = S_RSP;
                        rdata_d = '0;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: state_d = S_CAP;
            S_CAP: begin
                if (wr_q) begin
                    state_d  = S_WR;
                    datain_d = merged;
                end else begin
                    state_d = S_RSP;
                    rdata_d = mem_dataout;
                end
            end
            S_WR: begin
                state_d = S_RSP;
                rdata_d = datain_q;
            end
            S_RSP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values, and the asynchronous reset clears the SRAM strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            datain_q <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            datain_q <= datain_d;
            rdata_q  <= rdata_d;
            if (accept) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
        end
    end

endmodule

// File: tb/tb_ssram_rmw_bridge.sv
// Directed bench for ssram_rmw_bridge with a registered-read SRAM model.
module tb_ssram_rmw_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_wr;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        mem_wr;
    logic [9:0]  mem_addr;
    logic [31:0] mem_datain, mem_dataout;

    logic        pl_en;
    logic [9:0]  pl_addr;
    logic [31:0] pl_data;
    logic [31:0] model_mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ssram_rmw_bridge #(.WADDR(10), .WDATA(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout)
    );

    // SRAM model; the preload port lets the bench seed words while the bridge is idle.
    always @(posedge clk) begin
        if (pl_en) model_mem[pl_addr] <= pl_data;
        else if (mem_wr) model_mem[mem_addr] <= mem_datain;
        mem_dataout <= model_mem[mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One request with rsp_ready=1; latency counts edges from the accept edge.
    task automatic do_txn(input logic wr, input logic [9:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int lat, output logic [31:0] rd,
                          output int npulse, output int first_wr);
        int n;
        lat = -1; rd = 'x; npulse = 0; first_wr = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_be = be;
        rsp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (mem_wr) begin
                npulse++;
                if (first_wr == 0) first_wr = k;
            end
            if (rsp_valid) begin
                lat = k;
                rd  = rsp_rdata;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        pre_en;
        logic [31:0] pre;
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_pulses;
        int          exp_first_wr;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int          lat, npulse, first_wr, k;
        logic [31:0] rd;

        vecs[0] = '{1'b0, 32'h0,        1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2, 1, 1, 32'hDEADBEEF};
        vecs[1] = '{1'b0, 32'h0,        1'b0, 10'h005, 32'h0,        4'h0, 32'hDEADBEEF, 3, 0, 0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 32'h11223344, 1'b1, 10'h3FF, 32'hAABBCCDD, 4'h5, 32'h11BB33DD, 4, 1, 3, 32'h11BB33DD};
        vecs[3] = '{1'b0, 32'h0,        1'b0, 10'h3FF, 32'h0,        4'h0, 32'h11BB33DD, 3, 0, 0, 32'h11BB33DD};
        vecs[4] = '{1'b1, 32'hCAFEF00D, 1'b1, 10'h010, 32'hFFFFFFFF, 4'h0, 32'h00000000, 1, 0, 0, 32'hCAFEF00D};
        vecs[5] = '{1'b0, 32'h0,        1'b0, 10'h010, 32'h0,        4'h0, 32'hCAFEF00D, 3, 0, 0, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 32'h00000000, 1'b1, 10'h020, 32'h5AFFFFFF, 4'h8, 32'h5A000000, 4, 1, 3, 32'h5A000000};
        vecs[7] = '{1'b1, 32'h01020304, 1'b1, 10'h021, 32'hAABBCCDD, 4'h6, 32'h01BBCC04, 4, 1, 3, 32'h01BBCC04};
        vecs[8] = '{1'b0, 32'h0,        1'b0, 10'h020, 32'h0,        4'h0, 32'h5A000000, 3, 0, 0, 32'h5A000000};

        rst_n = 1'b0; req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h155;
        req_wdata = 32'h12345678; req_be = 4'hF; rsp_ready = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;

        // Reset held for three cycles with a request pending.
        repeat (3) begin
            @(negedge clk);
            check("rst_req_ready", {31'b0, req_ready}, 32'd0);
            check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            check("rst_mem_wr",    {31'b0, mem_wr},    32'd0);
        end
        check("rst_rsp_rdata",  rsp_rdata,          32'd0);
        check("rst_mem_addr",   {22'b0, mem_addr},  32'd0);
        check("rst_mem_datain", mem_datain,         32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].pre_en) preload(vecs[i].addr, vecs[i].pre);
            do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, lat, rd, npulse, first_wr);
            check($sformatf("v%0d_latency", i),  lat,      vecs[i].exp_lat);
            check($sformatf("v%0d_rdata", i),    rd,       vecs[i].exp_rdata);
            check($sformatf("v%0d_wr_pulses", i), npulse,  vecs[i].exp_pulses);
            check($sformatf("v%0d_wr_cycle", i), first_wr, vecs[i].exp_first_wr);
            check($sformatf("v%0d_mem", i), model_mem[vecs[i].addr], vecs[i].exp_mem);
        end

        // Backpressure: response held 5 cycles while a second request waits.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h005; rsp_ready = 1'b0;
        @(negedge clk);
        req_addr = 10'h3FF;
        k = 0;
        while (!rsp_valid && k < 10) begin
            check("bp_wait_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
            k++;
        end
        check("bp_rsp_seen", {31'b0, rsp_valid}, 32'd1);
        repeat (5) begin
            check("bp_valid_hold", {31'b0, rsp_valid}, 32'd1);
            check("bp_rdata_hold", rsp_rdata, 32'hDEADBEEF);
            check("bp_ready_low",  {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_no_accept_in_hs", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("bp_idle_after_hs", {31'b0, req_ready}, 32'd1);
        check("bp_valid_dropped", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("bp_second_accepted", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b0;
        lat = -1;
        for (int j = 1; j <= 20; j++) begin
            if (rsp_valid) begin
                lat = j;
                rd  = rsp_rdata;
                break;
            end
            @(negedge clk);
        end
        check("bp_second_latency", lat, 32'd3);
        check("bp_second_rdata",   rd,  32'h11BB33DD);

        // Reset during CAP of a single-byte RMW.
        preload(10'h030, 32'h12345678);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h030;
        req_wdata = 32'hFFFFFFAB; req_be = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid_rd_no_wr", {31'b0, mem_wr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_wr",   {31'b0, mem_wr},    32'd0);
        check("mid_rst_rsp",      {31'b0, rsp_valid}, 32'd0);
        check("mid_rst_ready",    {31'b0, req_ready}, 32'd0);
        check("mid_rst_mem_addr", {22'b0, mem_addr},  32'd0);
        repeat (2) begin
            @(negedge clk);
            check("mid_hold_mem_wr", {31'b0, mem_wr}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("mid_after_mem_wr", {31'b0, mem_wr},    32'd0);
            check("mid_after_rsp",    {31'b0, rsp_valid}, 32'd0);
        end
        check("mid_mem_intact", model_mem[10'h030], 32'h12345678);
        do_txn(1'b0, 10'h030, 32'h0, 4'h0, lat, rd, npulse, first_wr);
        check("mid_readback", rd, 32'h12345678);
        check("mid_readback_latency", lat, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ssram_rmw_bridge.md
# ssram_rmw_bridge

- Request-side front end for the single-port synchronous SRAM model (one registered read per cycle, write when `wr`=1, no byte enables).
- Accepts word requests with per-byte enables on a valid/ready bus and returns one response per request on a valid/ready bus.
- Partial-byte stores become read-modify-write sequences.
- Sits between the CPU-side bus of the test environment and the SRAM's `wr`/`addr`/`datain`/`dataout` pins.

## Interface

- `WADDR`, 10, word address width; must match the SRAM.
- `WDATA`, 32, data width; multiple of 8.
- `clk` in 1, rising-edge clock shared with the SRAM.
- `rst_n` in 1, asynchronous, active-low reset.
- `req_valid` in 1, request present.
- `req_ready` out 1, bridge can accept.
- `req_wr` in 1, 1 = write, 0 = read.
- `req_addr` in WADDR, word address.
- `req_wdata` in WDATA, write data.
- `req_be` in WDATA/8, byte enables; bit i covers bits [8i+7:8i].
- `rsp_valid` out 1, response present.
- `rsp_ready` in 1, response consumer ready.
- `rsp_rdata` out WDATA, read data (reads) or resulting stored word (writes).
- `mem_wr` out 1, SRAM write strobe.
- `mem_addr` out WADDR, SRAM address.
- `mem_datain` out WDATA, SRAM write data.
- `mem_dataout` in WDATA, SRAM registered read data.

## Operation

- States: IDLE, RD, CAP, WR, RSP. One request in flight at most.
- IDLE:
  - `req_ready`=1.
  - On `req_valid & req_ready` at a rising edge, latch wr, addr, wdata and be.
  - Next state:
    - read → RD
    - write with all be set → WR
    - write with be=0 → RSP (no SRAM access, `rsp_rdata`=0)
    - other write → RD
- RD: `mem_wr`=0, `mem_addr`=latched addr. Next state CAP.
- CAP:
  - `mem_dataout` now holds the word read in RD; capture it.
  - Read: `rsp_rdata` ← captured word, next state RSP.
  - Partial write: build the merged word, next state WR.
  - Merge: byte i = be[i] ? wdata byte i : old byte i.
- WR: `mem_wr`=1, `mem_addr`=latched addr, `mem_datain` = merged word (full write: wdata). `rsp_rdata` ← that word. Next state RSP.
- RSP: `rsp_valid`=1, `rsp_rdata` held stable. Stays in RSP until `rsp_valid & rsp_ready`, then goes to IDLE.
- `req_ready`=0 in every state except IDLE. No new request is accepted in the RSP handshake cycle.
- `mem_wr` is 1 only in WR.
- `mem_addr` holds its last value in IDLE. Idle SRAM reads are harmless and `mem_dataout` is ignored outside CAP.
- Reset (async, `rst_n`=0):
  - State goes to IDLE. `req_ready`=0 while `rst_n`=0.
  - `rsp_valid`=0; `rsp_rdata`, `mem_addr` and `mem_datain` =0; `mem_wr`=0 immediately.
  - Reset mid-sequence abandons the request with no response. An RMW interrupted before WR leaves memory unchanged.

## Timing

Request accepted at edge A (cycle A is the accept cycle):

- Read: RD in A+1, CAP in A+2, `rsp_valid` from A+3.
- Full write: WR in A+1, `rsp_valid` from A+2.
- Partial write: RD A+1, CAP A+2, WR A+3, `rsp_valid` from A+4.
- be=0 write: `rsp_valid` from A+1.
- Response handshake at edge R means IDLE in R+1, so the next accept is earliest at edge R+1.
- Best-case throughput: read 1 per 4 cycles, full write 1 per 3, partial write 1 per 5.
- `mem_*` outputs change only on clock edges, except the reset clear.

## Test plan

- Reset: hold `rst_n`=0 for 3 cycles with `req_valid`=1 → `req_ready`=0, `rsp_valid`=0, `mem_wr`=0, all outputs 0. After release, `req_ready`=1 in the first cycle.
- Full write then read: write addr 0x005, data 0xDEADBEEF, be=4'hF, `rsp_ready`=1 → `mem_wr` pulses once at A+1 and `rsp_valid` at A+2 with 0xDEADBEEF. Then read addr 0x005 → `rsp_rdata`=0xDEADBEEF at A+3.
- Partial write: preload 0x11223344 at 0x3FF, write 0xAABBCCDD with be=4'b0101 → exactly one RD and one WR. Write response and a subsequent read both return 0x11BB33DD.
- be=0 write to 0x010 holding 0xCAFEF00D → no `mem_wr` pulse, response at A+1 with 0. A later read returns 0xCAFEF00D.
- Backpressure: read with `rsp_ready`=0 for 5 cycles → `rsp_valid` and `rsp_rdata` stay stable, `req_ready`=0 throughout. A second request held on `req_valid` is accepted exactly one cycle after the response handshake.
- Reset mid-RMW: assert `rst_n`=0 during CAP of a be=4'b0001 write to a location holding 0x12345678 → no response, `mem_wr` never 1. After reset the location still reads 0x12345678.
